// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the memory port arbiter slice: the arbiter state
//   encoding (grant owner is implied by the state) and the default watchdog
//   timeout in cycles.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,  // no transaction outstanding
    ARB_BUSY_I = 2'd1,  // instruction fetch owns the external port
    ARB_BUSY_D = 2'd2   // load/store owns the external port
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the core-side fetch/data request signals, the external memory
//   port and the sticky error flag.
//   modport master : the arbiter (takes core requests, masters the external
//                    memory port, returns stalls/read data/error).
//   modport slave  : the surroundings (core + memory controller).
//   Handshake: a core request (inst_ren, or data_ren/data_wen) is held
//   stable while its stall is 1; the transfer completes in the cycle its
//   stall falls, and read data is valid only in that cycle. On the memory
//   side ext_req/ext_we/ext_addr/ext_wdata stay constant until ext_ack, a
//   one-cycle completion pulse that carries ext_rdata for reads.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_port_arbiter_pkg::*;

  logic              inst_ren;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_data;
  logic              inst_stall;

  logic              data_ren;
  logic              data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_err;

  modport master (
    input  inst_ren, inst_addr,
    input  data_ren, data_wen, data_addr, data_wdata,
    input  ext_ack, ext_rdata,
    output inst_data, inst_stall,
    output data_rdata, data_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_err
  );

  modport slave (
    output inst_ren, inst_addr,
    output data_ren, data_wen, data_addr, data_wdata,
    output ext_ack, ext_rdata,
    input  inst_data, inst_stall,
    input  data_rdata, data_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_err
  );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// arb_watchdog
//   Counts cycles a granted transaction waits for its ack. The count is
//   cleared on grant, steps while count_en is high and saturates at TIMEOUT.
//   err sets on the edge the count reaches TIMEOUT and stays set until
//   reset. TIMEOUT = 0 leaves the count at zero, so err never sets.
//   Ports: clk, rst (sync, active-low), clear, count_en, err.
module arb_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != LIMIT)) begin
      cnt <= cnt_inc;
      if (cnt_inc == LIMIT) err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one multi-cycle memory port between instruction fetch and
//   load/store. Data requests win; grants are issued from IDLE only, so
//   back-to-back transactions are separated by one IDLE cycle. A watchdog
//   raises the sticky mem_err when a transaction waits TIMEOUT cycles.
//   Ports: clk, rst (sync, active-low), bus (mem_port_arbiter_if.master),
//          dbg_state (current arbiter state, for observation only).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus,
  output arb_state_t          dbg_state
);

  arb_state_t        state, state_next;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant;
  logic              data_req;
  logic              ack_i, ack_d;

  assign data_req = bus.data_ren | bus.data_wen;
  // An ack only means something while a transaction is outstanding; a stray
  // ack in IDLE (e.g. after a reset abandoned a transaction) is ignored.
  assign ack_i = (state == ARB_BUSY_I) & bus.ext_ack;
  assign ack_d = (state == ARB_BUSY_D) & bus.ext_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_next;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_next = state;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant      = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (data_req) begin
          state_next = ARB_BUSY_D;
          req_d      = 1'b1;
          we_d       = bus.data_wen;
          addr_d     = bus.data_addr;
          wdata_d    = bus.data_wdata;
          grant      = 1'b1;
        end else if (bus.inst_ren) begin
          state_next = ARB_BUSY_I;
          req_d      = 1'b1;
          we_d       = 1'b0;
          addr_d     = bus.inst_addr;
          grant      = 1'b1;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        // A fetch flushed mid-flight still runs to its ack; only the
        // returned word is dropped.
        if (bus.ext_ack) begin
          state_next = ARB_IDLE;
          req_d      = 1'b0;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        req_d      = 1'b0;
      end
    endcase
  end

  assign bus.ext_req   = req_q;
  assign bus.ext_we    = we_q;
  assign bus.ext_addr  = addr_q;
  assign bus.ext_wdata = wdata_q;

  assign bus.inst_stall = bus.inst_ren & ~ack_i;
  assign bus.data_stall = data_req & ~ack_d;

  // Read data is exposed only in the owner's ack cycle; a flushed fetch and
  // a store ack return nothing.
  assign bus.inst_data  = (ack_i & bus.inst_ren) ? bus.ext_rdata : '0;
  assign bus.data_rdata = (ack_d & ~we_q) ? bus.ext_rdata : '0;

  assign dbg_state = state;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (grant),
    .count_en ((state != ARB_IDLE) & ~bus.ext_ack),
    .err      (bus.mem_err)
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, multi-cycle memory port between the core's instruction-fetch interface (inst_ren/inst_addr/inst_data) and data interface (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).
- Sits between mips_core and the external memory controller.
- Generates per-requester stall signals that feed the pipeline's if_en/mem_en gating.
- Data requests get priority; a watchdog flags a hung memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, cycles a granted transaction may wait for mem_ack before mem_err asserts; 0 disables the watchdog.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- inst_ren  in  1  fetch request; held stable by the core while inst_stall=1.
- inst_addr  in  ADDR_W  fetch address.
- inst_data  out  DATA_W  fetched word; valid only in the cycle inst_stall falls.
- inst_stall  out  1  fetch not yet complete.
- data_ren  in  1  load request.
- data_wen  in  1  store request; data_ren and data_wen must not both be 1.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  load result; valid only in the cycle data_stall falls.
- data_stall  out  1  load/store not yet complete.
- ext_req  out  1  transaction request to memory.
- ext_we  out  1  write strobe.
- ext_addr  out  ADDR_W  transaction address.
- ext_wdata  out  DATA_W  write data.
- ext_ack  in  1  one-cycle completion pulse.
- ext_rdata  in  DATA_W  read data, valid with ext_ack.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Grant owner is encoded by state.
- Reset (rst=0 at a clk edge):
  - Forces IDLE, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, mem_err=0, watchdog count=0.
  - inst_data and data_rdata read 0 and the stalls are combinational, so both stalls follow their request inputs.
  - Reset mid-transaction abandons it; a late ext_ack after reset is ignored (ack in IDLE has no effect).
- IDLE:
  - If data_ren|data_wen, register data_addr/data_wdata/data_wen into ext_*, set ext_req=1, go to BUSY_D.
  - Else if inst_ren, register inst_addr, ext_we=0, ext_req=1, go to BUSY_I.
  - Simultaneous requests: data wins; the fetch waits, and is granted in the cycle after the data ack at the earliest.
- ext_req, ext_addr, ext_we and ext_wdata are registered and held constant until the ack cycle.
- In the ack cycle:
  - ext_req drops at the next edge, and the state returns to IDLE.
  - There is one IDLE bubble between back-to-back transactions, so minimum latency is 2 cycles (grant edge, then ack).
- Stalls (combinational):
  - inst_stall = inst_ren & ~(state==BUSY_I & ext_ack).
  - data_stall = (data_ren|data_wen) & ~(state==BUSY_D & ext_ack).
  - inst_data = ext_rdata and data_rdata = ext_rdata, each gated to 0 except in its own ack cycle.
- Flush: if inst_ren drops while in BUSY_I (branch redirect), the transaction still completes; its ack is consumed and its data discarded (inst_stall already 0).
- Requests seen in IDLE must still be asserted to be granted; dropped requests are never granted.
- Watchdog:
  - Counter clears on entry to BUSY_* and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, mem_err sets (sticky until reset). The transaction is not aborted.
  - The counter saturates at TIMEOUT.
- Store ack carries no read data; data_rdata stays 0 on a store ack.

Decomposition:
- Shared package (define.vh style): state encoding constants ARB_IDLE=2'd0, ARB_BUSY_I=2'd1, ARB_BUSY_D=2'd2; default TIMEOUT value.
- One sub-module: arb_watchdog (clear, count-enable, saturating counter, sticky err output).
- The FSM and muxing stay in mem_port_arbiter.

Test Plan:
- Fetch only:
  - Stimulus: inst_ren=1, inst_addr=0x0000_0040; memory acks 3 cycles after ext_req with rdata=0x2408_0005.
  - Required: ext_req rises one edge later with ext_addr=0x40, ext_we=0; inst_stall=1 until the ack cycle; inst_data=0x24080005 in that cycle.
- Simultaneous requests:
  - Stimulus: inst_ren and data_wen with data_addr=0x100, wdata=0xDEADBEEF.
  - Required: first ext transaction is a write to 0x100 carrying 0xDEADBEEF; the fetch is issued after exactly one IDLE cycle; inst_stall stays 1 throughout the store.
- Load:
  - Stimulus: data_ren at 0x200; ack with rdata=0x1234_5678 after 1 cycle.
  - Required: data_rdata=0x12345678 only in the ack cycle, 0 otherwise; data_stall falls in the same cycle.
- Flush during fetch:
  - Stimulus: drop inst_ren while in BUSY_I.
  - Required: inst_stall=0 immediately; the ack is absorbed, state returns to IDLE, and no new ext_req is issued.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack.
  - Required: mem_err=1 after 4 BUSY cycles; it stays 1 after a later ack; it clears only with rst=0.
- Reset mid-transaction:
  - Stimulus: rst=0 for one cycle while in BUSY_D, then a stray ack.
  - Required: all ext_* outputs are 0 after the edge; the stray ack causes no output change; the next request is served normally.
